// File: rtl/mem_access_unit.sv
// Load/store stage with a fixed-latency word memory, byte-lane stores,
// filtered loads and a side-band debug read port.
module mem_access_unit #(
    parameter int PROC_BITS       = 32,
    parameter int DATA_ADDRS_BITS = 10,
    parameter int REG_ADDRS_BITS  = 5,
    parameter int MEM_LATENCY     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [PROC_BITS-1:0]       i_alu_data,
    input  logic [PROC_BITS-1:0]       i_store_data,
    input  logic [REG_ADDRS_BITS-1:0]  i_rd,
    input  logic                       i_RegWrite,
    input  logic                       i_MemRead,
    input  logic                       i_MemWrite,
    input  logic                       i_MemtoReg,
    input  logic [2:0]                 i_ls_filter_op,
    input  logic                       i_debug_req,
    input  logic [DATA_ADDRS_BITS-1:0] i_debug_addr,
    output logic                       o_debug_valid,
    output logic [PROC_BITS-1:0]       o_debug_data,
    output logic                       o_valid,
    output logic [PROC_BITS-1:0]       o_alu_data,
    output logic [PROC_BITS-1:0]       o_mem_data,
    output logic [REG_ADDRS_BITS-1:0]  o_rd,
    output logic                       o_RegWrite,
    output logic                       o_MemtoReg,
    output logic                       o_misaligned
);

    localparam int DEPTH = 2 ** DATA_ADDRS_BITS;
    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DEBUG = 2'd2
    } state_t;

    state_t state;
    logic [3:0] cnt;

    logic [PROC_BITS-1:0] mem [DEPTH];

    logic [DATA_ADDRS_BITS-1:0] acc_idx;
    logic [1:0]                 acc_off;
    logic                       is_byte;
    logic                       is_half;
    logic                       mem_op;
    logic                       misal;
    logic                       accept;
    logic                       st_en;
    logic [3:0]                 st_be;
    logic [PROC_BITS-1:0]       st_data;

    logic [PROC_BITS-1:0]       op_alu;
    logic [REG_ADDRS_BITS-1:0]  op_rd;
    logic                       op_regwrite;
    logic                       op_memtoreg;
    logic                       op_load;
    logic [2:0]                 op_filt;
    logic [DATA_ADDRS_BITS-1:0] op_idx;
    logic [1:0]                 op_off;
    logic [DATA_ADDRS_BITS-1:0] dbg_idx;

    logic unused_addr_bits;
    assign unused_addr_bits = ^i_alu_data[PROC_BITS-1:DATA_ADDRS_BITS+2];

    assign acc_idx = i_alu_data[DATA_ADDRS_BITS+1:2];
    assign acc_off = i_alu_data[1:0];
    assign is_byte = (i_ls_filter_op[1:0] == 2'b00);
    assign is_half = (i_ls_filter_op[1:0] == 2'b01);
    assign mem_op  = i_MemRead | i_MemWrite;

    always_comb begin
        misal = 1'b0;
        if (mem_op) begin
            if (is_half)
                misal = acc_off[0];
            else if (!is_byte)
                misal = (acc_off != 2'b00);
        end
    end

    assign o_ready = (state == IDLE) && !i_debug_req;
    assign accept  = i_valid && o_ready && !rst;
    assign st_en   = accept && i_MemWrite && !misal;

    always_comb begin
        st_be   = 4'b1111;
        st_data = i_store_data;
        if (is_byte) begin
            st_be   = 4'b0001 << acc_off;
            st_data = {4{i_store_data[7:0]}};
        end else if (is_half) begin
            st_be   = 4'b0011 << acc_off;
            st_data = {2{i_store_data[15:0]}};
        end
    end

    // Stores commit at the accept edge; memory is never cleared by reset.
    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b])
                    mem[acc_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    function automatic logic [PROC_BITS-1:0] load_ext(
        input logic [PROC_BITS-1:0] w,
        input logic [1:0]           off,
        input logic [2:0]           f
    );
        logic [PROC_BITS-1:0] sh;
        sh = w >> {off, 3'b000};
        case (f[1:0])
            2'b00:   load_ext = f[2] ? {24'd0, sh[7:0]}
                                     : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_ext = f[2] ? {16'd0, sh[15:0]}
                                     : {{16{sh[15]}}, sh[15:0]};
            default: load_ext = w;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            op_alu        <= '0;
            op_rd         <= '0;
            op_regwrite   <= 1'b0;
            op_memtoreg   <= 1'b0;
            op_load       <= 1'b0;
            op_filt       <= '0;
            op_idx        <= '0;
            op_off        <= '0;
            dbg_idx       <= '0;
            o_valid       <= 1'b0;
            o_alu_data    <= '0;
            o_mem_data    <= '0;
            o_rd          <= '0;
            o_RegWrite    <= 1'b0;
            o_MemtoReg    <= 1'b0;
            o_misaligned  <= 1'b0;
            o_debug_valid <= 1'b0;
            o_debug_data  <= '0;
        end else begin
            o_valid       <= 1'b0;
            o_debug_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_debug_req) begin
                        state   <= DEBUG;
                        cnt     <= LAT;
                        dbg_idx <= i_debug_addr;
                    end else if (i_valid) begin
                        op_alu      <= i_alu_data;
                        op_rd       <= i_rd;
                        op_regwrite <= i_RegWrite;
                        op_memtoreg <= i_MemtoReg;
                        op_load     <= i_MemRead && !i_MemWrite;
                        op_filt     <= i_ls_filter_op;
                        op_idx      <= acc_idx;
                        op_off      <= acc_off;
                        if (mem_op && !misal) begin
                            state <= BUSY;
                            cnt   <= LAT;
                        end else begin
                            o_valid      <= 1'b1;
                            o_alu_data   <= i_alu_data;
                            o_mem_data   <= '0;
                            o_rd         <= i_rd;
                            o_RegWrite   <= i_RegWrite && !misal;
                            o_MemtoReg   <= i_MemtoReg;
                            o_misaligned <= misal;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        o_valid      <= 1'b1;
                        o_alu_data   <= op_alu;
                        o_mem_data   <= op_load
                            ? load_ext(mem[op_idx], op_off, op_filt)
                            : '0;
                        o_rd         <= op_rd;
                        o_RegWrite   <= op_regwrite;
                        o_MemtoReg   <= op_memtoreg;
                        o_misaligned <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DEBUG: begin
                    if (cnt == 4'd1) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        o_debug_valid <= 1'b1;
                        o_debug_data  <= mem[dbg_idx];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, filtered loads,
// misalignment, debug reads, priority and reset abort.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_alu_data = '0;
    logic [31:0] i_store_data = '0;
    logic [4:0]  i_rd = '0;
    logic        i_RegWrite = 1'b0;
    logic        i_MemRead = 1'b0;
    logic        i_MemWrite = 1'b0;
    logic        i_MemtoReg = 1'b0;
    logic [2:0]  i_ls_filter_op = '0;
    logic        i_debug_req = 1'b0;
    logic [9:0]  i_debug_addr = '0;
    logic        o_debug_valid;
    logic [31:0] o_debug_data;
    logic        o_valid;
    logic [31:0] o_alu_data;
    logic [31:0] o_mem_data;
    logic [4:0]  o_rd;
    logic        o_RegWrite;
    logic        o_MemtoReg;
    logic        o_misaligned;

    int checks = 0;
    int failures = 0;
    int lat;
    int w;
    int pulses;

    mem_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_alu_data     (i_alu_data),
        .i_store_data   (i_store_data),
        .i_rd           (i_rd),
        .i_RegWrite     (i_RegWrite),
        .i_MemRead      (i_MemRead),
        .i_MemWrite     (i_MemWrite),
        .i_MemtoReg     (i_MemtoReg),
        .i_ls_filter_op (i_ls_filter_op),
        .i_debug_req    (i_debug_req),
        .i_debug_addr   (i_debug_addr),
        .o_debug_valid  (o_debug_valid),
        .o_debug_data   (o_debug_data),
        .o_valid        (o_valid),
        .o_alu_data     (o_alu_data),
        .o_mem_data     (o_mem_data),
        .o_rd           (o_rd),
        .o_RegWrite     (o_RegWrite),
        .o_MemtoReg     (o_MemtoReg),
        .o_misaligned   (o_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency counts cycles after the accept edge until o_valid is seen.
    task automatic issue(input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw,
                         input logic mr, input logic mw,
                         input logic m2r, input logic [2:0] f,
                         output int l);
        int n;
        n = 0;
        i_alu_data = a;
        i_store_data = sd;
        i_rd = rd;
        i_RegWrite = rw;
        i_MemRead = mr;
        i_MemWrite = mw;
        i_MemtoReg = m2r;
        i_ls_filter_op = f;
        i_valid = 1'b1;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        if (!o_ready) chk("ready_timeout", {31'd0, o_ready}, 32'd1);
        tick();
        i_valid = 1'b0;
        l = 1;
        while (!o_valid && l < 20) begin
            tick();
            l++;
        end
    endtask

    task automatic dbg(input logic [9:0] addr, output int l);
        i_debug_addr = addr;
        i_debug_req = 1'b1;
        tick();
        i_debug_req = 1'b0;
        l = 1;
        while (!o_debug_valid && l < 20) begin
            tick();
            l++;
        end
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_outs", {o_valid, o_debug_valid, o_RegWrite, o_MemtoReg,
                         o_misaligned, o_rd}, 32'd0);
        chk("rst_data", o_alu_data | o_mem_data | o_debug_data, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        issue(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
              3'b010, lat);
        chk("sw_lat", lat, 32'd3);
        chk("sw_mis", {31'd0, o_misaligned}, 32'd0);
        tick();
        chk("sw_pulse", {31'd0, o_valid}, 32'd0);
        dbg(10'd4, lat);
        chk("dbg_lat", lat, 32'd3);
        chk("dbg_w4", o_debug_data, 32'hDEADBEEF);
        tick();
        chk("dbg_pulse", {31'd0, o_debug_valid}, 32'd0);

        issue(32'h11, 32'h0000007F, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
              3'b000, lat);
        chk("sb_lat", lat, 32'd3);
        dbg(10'd4, lat);
        chk("sb_word", o_debug_data, 32'hDEAD7FEF);
        issue(32'h12, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, lat);
        chk("lh_lat", lat, 32'd3);
        chk("lh_data", o_mem_data, 32'hFFFFDEAD);
        chk("lh_rd", {27'd0, o_rd}, 32'd9);
        chk("lh_ctl", {30'd0, o_RegWrite, o_MemtoReg}, 32'd3);
        issue(32'h11, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, lat);
        chk("lbu_data", o_mem_data, 32'h0000007F);
        issue(32'h10, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, lat);
        chk("lw_data", o_mem_data, 32'hDEAD7FEF);

        issue(32'h13, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, lat);
        chk("mis_lat", lat, 32'd1);
        chk("mis_flag", {31'd0, o_misaligned}, 32'd1);
        chk("mis_rw", {31'd0, o_RegWrite}, 32'd0);
        chk("mis_mdata", o_mem_data, 32'd0);
        issue(32'h11, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
              3'b001, lat);
        chk("mis_sh_lat", lat, 32'd1);
        chk("mis_sh_flag", {31'd0, o_misaligned}, 32'd1);
        dbg(10'd4, lat);
        chk("mis_sh_mem", o_debug_data, 32'hDEAD7FEF);

        issue(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, lat);
        chk("alu_lat", lat, 32'd1);
        chk("alu_data", o_alu_data, 32'h55);
        chk("alu_rd", {27'd0, o_rd}, 32'd3);
        chk("alu_rw", {31'd0, o_RegWrite}, 32'd1);
        chk("alu_mis", {31'd0, o_misaligned}, 32'd0);

        issue(32'h20, 32'h11223344, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
              3'b010, lat);
        issue(32'h22, 32'h0000ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
              3'b101, lat);
        dbg(10'd8, lat);
        chk("sh_word", o_debug_data, 32'hABCD3344);
        issue(32'h22, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101, lat);
        chk("lhu_data", o_mem_data, 32'h0000ABCD);
        issue(32'h23, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, lat);
        chk("lb_data", o_mem_data, 32'hFFFFFFAB);
        issue(32'h20, 32'h99, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, lat);
        chk("rw_both_lat", lat, 32'd3);
        chk("rw_both_mdata", o_mem_data, 32'd0);
        dbg(10'd8, lat);
        chk("rw_both_mem", o_debug_data, 32'hABCD3399);

        i_alu_data = 32'h77;
        i_rd = 5'd7;
        i_RegWrite = 1'b1;
        i_MemRead = 1'b0;
        i_MemWrite = 1'b0;
        i_MemtoReg = 1'b0;
        i_valid = 1'b1;
        i_debug_addr = 10'd4;
        i_debug_req = 1'b1;
        #1;
        chk("prio_ready", {31'd0, o_ready}, 32'd0);
        tick();
        i_debug_req = 1'b0;
        chk("prio_no_op", {31'd0, o_valid}, 32'd0);
        w = 1;
        while (!o_debug_valid && w < 20) begin
            tick();
            w++;
        end
        chk("prio_dbg_lat", w, 32'd3);
        chk("prio_dbg_data", o_debug_data, 32'hDEAD7FEF);
        chk("prio_ready2", {31'd0, o_ready}, 32'd1);
        tick();
        i_valid = 1'b0;
        chk("prio_op_valid", {31'd0, o_valid}, 32'd1);
        chk("prio_op_data", o_alu_data, 32'h77);

        i_alu_data = 32'h20;
        i_rd = 5'd5;
        i_RegWrite = 1'b1;
        i_MemRead = 1'b1;
        i_MemtoReg = 1'b1;
        i_ls_filter_op = 3'b010;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("ra_ready", {31'd0, o_ready}, 32'd1);
        chk("ra_outs", {o_valid, o_debug_valid, o_RegWrite, o_MemtoReg,
                        o_misaligned, o_rd}, 32'd0);
        chk("ra_alu", o_alu_data, 32'd0);
        chk("ra_dbg", o_debug_data, 32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_valid) pulses++;
            tick();
        end
        chk("ra_no_valid", pulses, 32'd0);
        chk("ra_ready_post", {31'd0, o_ready}, 32'd1);
        dbg(10'd8, lat);
        chk("ra_mem_kept", o_debug_data, 32'hABCD3399);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter PROC_BITS, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter DATA_ADDRS_BITS, default 10, word-address width; depth = 2^DATA_ADDRS_BITS words.
REQ-003 SHALL have parameter REG_ADDRS_BITS, default 5, destination register address width.
REQ-004 SHALL have parameter MEM_LATENCY, default 2, memory access cycles; legal range 1..8.
REQ-005 SHALL have one clock and an active-high asynchronous reset, with these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active high.
- i_valid  in  1  operation presented.
- o_ready  out  1  unit can accept an operation.
- i_alu_data  in  PROC_BITS  byte address, or pass-through result.
- i_store_data  in  PROC_BITS  store source.
- i_rd  in  REG_ADDRS_BITS  destination register.
- i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg  in  1 each  control bits.
- i_ls_filter_op  in  3  access size/sign: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
- i_debug_req  in  1  debug read request.
- i_debug_addr  in  DATA_ADDRS_BITS  debug word address.
- o_debug_valid  out  1  debug data valid, one-cycle pulse.
- o_debug_data  out  PROC_BITS  raw memory word.
- o_valid  out  1  result valid, one-cycle pulse.
- o_alu_data, o_mem_data  out  PROC_BITS each  pass-through value / filtered load data.
- o_rd  out  REG_ADDRS_BITS  destination register.
- o_RegWrite, o_MemtoReg  out  1 each  forwarded control.
- o_misaligned  out  1  access fault, valid with o_valid.

Function
REQ-006 Addressing SHALL be: word index = i_alu_data[DATA_ADDRS_BITS+1:2]; byte offset = i_alu_data[1:0]; higher address bits ignored.
REQ-007 FSM states SHALL be IDLE, BUSY and DEBUG; o_ready SHALL be 1 only in IDLE with i_debug_req=0.
REQ-008 An operation SHALL be accepted on a rising edge where i_valid=1 and o_ready=1; all inputs are captured at that edge, and inputs in other cycles are ignored.
REQ-009 A non-memory operation (MemRead=MemWrite=0) accepted in cycle T SHALL produce o_valid=1 in cycle T+1 with forwarded fields; state stays IDLE.
REQ-010 An aligned memory operation accepted in cycle T SHALL enter BUSY for MEM_LATENCY cycles (down-counter), return to IDLE, and pulse o_valid in cycle T+MEM_LATENCY+1.
REQ-011 A store SHALL commit at the accept edge using byte-lane enables: byte lane = offset; half lanes = {offset+1, offset}; word = all lanes. Data SHALL be replicated into the selected lanes, and unselected lanes are unchanged.
REQ-012 A load SHALL capture the word at the end of the last BUSY cycle, extract the addressed byte/half, then sign- or zero-extend per i_ls_filter_op; o_mem_data SHALL be 0 for non-loads.
REQ-013 Misalignment (half with offset[0]=1, or word with offset!=0) on a memory op SHALL behave as REQ-009 with o_misaligned=1, o_RegWrite=0, and no memory write.
REQ-014 If MemRead and MemWrite are both 1, the operation SHALL be treated as a store, and o_mem_data SHALL be 0.
REQ-015 A debug request sampled in IDLE SHALL take priority over i_valid, enter DEBUG for MEM_LATENCY cycles, then pulse o_debug_valid with the unfiltered word; no write can occur in DEBUG.
REQ-016 i_debug_req raised during BUSY SHALL be served after return to IDLE.
REQ-017 o_valid/o_debug_valid SHALL be high exactly one cycle per operation; other outputs hold their last value between pulses.
REQ-018 Back-to-back: a new op may be accepted in the same cycle o_valid is high, if o_ready=1.

Reset
REQ-019 rst=1 SHALL immediately force state IDLE, counter 0, and every output register to 0 (o_ready then 1).
REQ-020 Reset mid-BUSY/DEBUG SHALL abort with no o_valid/o_debug_valid; a store already committed SHALL remain; memory contents are not cleared.

Verification
REQ-021 MEM_LATENCY=2: store word 0xDEADBEEF to addr 0x10 at T -> o_valid at T+3; debug read word 4 -> o_debug_data=0xDEADBEEF.
REQ-022 Store byte 0x7F to 0x11 over 0xDEADBEEF -> word 0xDEAD7FEF; load half signed 0x12 -> o_mem_data=0xFFFFDEAD; load byte unsigned 0x11 -> 0x0000007F.
REQ-023 Load word at 0x13 -> o_valid at T+1, o_misaligned=1, o_RegWrite=0, memory unchanged.
REQ-024 Non-memory op with i_alu_data=0x55, i_rd=3, RegWrite=1 -> next cycle o_valid=1, o_alu_data=0x55, o_rd=3, o_RegWrite=1.
REQ-025 i_debug_req and i_valid asserted together in IDLE -> debug served first (o_ready=0), op accepted after o_debug_valid.
REQ-026 rst asserted in the second BUSY cycle of a load -> all outputs 0 at once, no o_valid pulse, o_ready=1 after release.
